// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and constants for the instruction/data SRAM arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester currently owns (or last owned) the SRAM
//   RD_WAIT_DEF / WR_WAIT_DEF : default extra strobe cycles
//   WAIT_CNT_W  : wait-counter width (covers wait values 0..15)
//   sram_word_addr() : byte address -> 20-bit SRAM word address
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int RD_WAIT_DEF = 1;
    localparam int WR_WAIT_DEF = 1;
    localparam int WAIT_CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        DONE     = 3'd5
    } arb_state_t;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } owner_t;

    // The SRAM is 32 bits wide and 1M words deep: bits [21:2] select the
    // word, everything above and the byte offset are not used.
    function automatic logic [19:0] sram_word_addr(input logic [31:0] byte_addr);
        return byte_addr[21:2];
    endfunction

endpackage

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Shares one asynchronous 32-bit SRAM between an instruction-fetch port and
// a load/store port. One transaction at a time; data and instruction
// requests alternate when both are pending so neither can starve.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   inst_req/inst_addr          fetch request (held until inst_ack)
//   inst_ack/inst_rdata         one-cycle completion pulse + fetched word
//   data_req/data_we/data_addr/data_wdata
//                               load/store request, we=0000 means load
//   data_ack/data_rdata         one-cycle completion pulse + loaded word
//   ram_data                    bidirectional SRAM data bus
//   ram_addr                    SRAM word address
//   ram_be_n/ram_ce_n/ram_oe_n/ram_we_n   active-low SRAM controls
//
// Every SRAM control, the bus-drive enable and both acks are flops: the FSM
// assigns them together with the state they belong to, so they change
// exactly on the state boundary and never glitch.
// ---------------------------------------------------------------------------
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int RD_WAIT = RD_WAIT_DEF,
    parameter int WR_WAIT = WR_WAIT_DEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_ack,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [3:0]  data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ack,
    output logic [31:0] data_rdata,

    inout  wire  [31:0] ram_data,
    output logic [19:0] ram_addr,
    output logic [3:0]  ram_be_n,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    // Counter reload values; the counter counts the extra cycles down to 0.
    localparam logic [WAIT_CNT_W-1:0] RD_LOAD = WAIT_CNT_W'(RD_WAIT);
    localparam logic [WAIT_CNT_W-1:0] WR_LOAD = WAIT_CNT_W'(WR_WAIT);

    arb_state_t              state_q;
    owner_t                  owner_q;
    owner_t                  last_owner_q;
    logic [WAIT_CNT_W-1:0]   cnt_q;
    logic [31:0]             wdata_q;
    logic                    drive_q;

    logic                    inst_ack_q;
    logic                    data_ack_q;
    logic [31:0]             inst_rdata_q;
    logic [31:0]             data_rdata_q;
    logic [19:0]             ram_addr_q;
    logic [3:0]              ram_be_n_q;
    logic                    ram_ce_n_q;
    logic                    ram_oe_n_q;
    logic                    ram_we_n_q;

    // Grant decision for the IDLE cycle
    owner_t                  grant_owner;
    logic                    grant_valid;
    logic                    grant_write;
    logic [31:0]             grant_addr;
    logic [3:0]              grant_be_n;

    // Only bits [21:2] of the byte addresses reach the SRAM.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[31:22], inst_addr[1:0],
                                data_addr[31:22], data_addr[1:0]};

    always_comb begin
        grant_valid = inst_req | data_req;
        grant_owner = INST;
        // Data wins a tie unless it was also the last port served.
        if (data_req && (!inst_req || (last_owner_q == INST))) begin
            grant_owner = DATA;
        end
        grant_write = (grant_owner == DATA) && (data_we != 4'b0000);
        grant_addr  = (grant_owner == DATA) ? data_addr : inst_addr;
        // Reads enable all four bytes; writes enable only the strobed bytes.
        grant_be_n  = grant_write ? ~data_we : 4'b0000;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            owner_q      <= INST;
            last_owner_q <= INST;
            cnt_q        <= '0;
            wdata_q      <= '0;
            drive_q      <= 1'b0;
            inst_ack_q   <= 1'b0;
            data_ack_q   <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            ram_addr_q   <= '0;
            ram_be_n_q   <= 4'b1111;
            ram_ce_n_q   <= 1'b1;
            ram_oe_n_q   <= 1'b1;
            ram_we_n_q   <= 1'b1;
        end else begin
            // Acks are single-cycle pulses raised only on entry to DONE.
            inst_ack_q <= 1'b0;
            data_ack_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        // Everything the transaction needs is captured here,
                        // so later input changes or a dropped request have
                        // no effect until the ack.
                        owner_q    <= grant_owner;
                        ram_addr_q <= sram_word_addr(grant_addr);
                        ram_be_n_q <= grant_be_n;
                        wdata_q    <= data_wdata;
                        ram_ce_n_q <= 1'b0;
                        ram_we_n_q <= 1'b1;
                        if (grant_write) begin
                            state_q    <= WR_SETUP;
                            ram_oe_n_q <= 1'b1;
                            drive_q    <= 1'b1;
                        end else begin
                            state_q    <= RD;
                            ram_oe_n_q <= 1'b0;
                            cnt_q      <= RD_LOAD;
                        end
                    end
                end

                RD: begin
                    if (cnt_q == '0) begin
                        // Last strobe cycle: the SRAM output has settled.
                        if (owner_q == DATA) begin
                            data_rdata_q <= ram_data;
                            data_ack_q   <= 1'b1;
                        end else begin
                            inst_rdata_q <= ram_data;
                            inst_ack_q   <= 1'b1;
                        end
                        last_owner_q <= owner_q;
                        state_q      <= DONE;
                        ram_ce_n_q   <= 1'b1;
                        ram_oe_n_q   <= 1'b1;
                        ram_be_n_q   <= 4'b1111;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                WR_SETUP: begin
                    // Address and data have been stable for a full cycle
                    // before we_n falls.
                    state_q    <= WR_PULSE;
                    ram_we_n_q <= 1'b0;
                    cnt_q      <= WR_LOAD;
                end

                WR_PULSE: begin
                    if (cnt_q == '0) begin
                        state_q    <= WR_HOLD;
                        ram_we_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                WR_HOLD: begin
                    // Data stays driven one cycle after we_n rises for hold time.
                    state_q      <= DONE;
                    drive_q      <= 1'b0;
                    ram_ce_n_q   <= 1'b1;
                    ram_be_n_q   <= 4'b1111;
                    last_owner_q <= owner_q;
                    if (owner_q == DATA) begin
                        data_ack_q <= 1'b1;
                    end else begin
                        inst_ack_q <= 1'b1;
                    end
                end

                DONE: begin
                    // Requests are not sampled here: the requester still sees
                    // its ack this cycle and must be allowed to drop req.
                    state_q <= IDLE;
                end

                default: begin
                    state_q    <= IDLE;
                    drive_q    <= 1'b0;
                    ram_ce_n_q <= 1'b1;
                    ram_oe_n_q <= 1'b1;
                    ram_we_n_q <= 1'b1;
                    ram_be_n_q <= 4'b1111;
                end
            endcase
        end
    end

    assign ram_data   = drive_q ? wdata_q : 32'bz;
    assign ram_addr   = ram_addr_q;
    assign ram_be_n   = ram_be_n_q;
    assign ram_ce_n   = ram_ce_n_q;
    assign ram_oe_n   = ram_oe_n_q;
    assign ram_we_n   = ram_we_n_q;
    assign inst_ack   = inst_ack_q;
    assign data_ack   = data_ack_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
// Directed bench for sram_arbiter: a table of single transactions with
// hand-computed results, plus hand-written sequences for the tie/alternation
// case, a request dropped mid-read, reset during a write pulse, and a second
// instance built with RD_WAIT=0.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;
    wire  [31:0] ram_data;
    logic [19:0] ram_addr;
    logic [3:0]  ram_be_n;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;

    // Second instance, RD_WAIT=0, used for loads only
    logic        b_inst_req = 1'b0;
    logic [31:0] b_inst_addr = 32'h0;
    logic        b_inst_ack;
    logic [31:0] b_inst_rdata;
    logic        b_data_req = 1'b0;
    logic [3:0]  b_data_we = 4'b0000;
    logic [31:0] b_data_addr = 32'h0;
    logic [31:0] b_data_wdata = 32'h0;
    logic        b_data_ack;
    logic [31:0] b_data_rdata;
    wire  [31:0] b_ram_data;
    logic [19:0] b_ram_addr;
    logic [3:0]  b_ram_be_n;
    logic        b_ram_ce_n;
    logic        b_ram_oe_n;
    logic        b_ram_we_n;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    sram_arbiter #(.RD_WAIT(1), .WR_WAIT(1)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_ack(inst_ack), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_be_n(ram_be_n),
        .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
    );

    sram_arbiter #(.RD_WAIT(0), .WR_WAIT(1)) dut_b (
        .clk(clk), .resetn(resetn),
        .inst_req(b_inst_req), .inst_addr(b_inst_addr),
        .inst_ack(b_inst_ack), .inst_rdata(b_inst_rdata),
        .data_req(b_data_req), .data_we(b_data_we), .data_addr(b_data_addr),
        .data_wdata(b_data_wdata), .data_ack(b_data_ack), .data_rdata(b_data_rdata),
        .ram_data(b_ram_data), .ram_addr(b_ram_addr), .ram_be_n(b_ram_be_n),
        .ram_ce_n(b_ram_ce_n), .ram_oe_n(b_ram_oe_n), .ram_we_n(b_ram_we_n)
    );

    // Asynchronous SRAM model: drives the bus during reads, byte-writes while we_n is low.
    assign ram_data   = (!ram_ce_n && !ram_oe_n && ram_we_n) ? mem[ram_addr[7:0]] : 32'bz;
    assign b_ram_data = (!b_ram_ce_n && !b_ram_oe_n && b_ram_we_n) ? mem[b_ram_addr[7:0]] : 32'bz;

    always @(posedge clk) begin
        if (!ram_ce_n && !ram_we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!ram_be_n[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_data[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one transaction on dut starting in an IDLE cycle (called at a negedge).
    // Inputs are scrambled right after the grant; drop_k>0 drops the request
    // at that cycle. Returns ack latency (-1 if none), who acked (0 inst,
    // 1 data, 2 both), strobe/bus cycle counts and first-cycle addr/be_n.
    task automatic do_txn(input logic ireq, input logic dreq, input logic [3:0] we,
                          input logic [31:0] addr, input logic [31:0] wdata, input int drop_k,
                          output int lat, output int who, output int oe_c, output int we_c,
                          output int bus_c, output int ack_c,
                          output logic [19:0] a1, output logic [3:0] be1);
        lat = -1; who = -1; oe_c = 0; we_c = 0; bus_c = 0; ack_c = 0; a1 = '0; be1 = '0;
        inst_req = ireq; inst_addr = addr;
        data_req = dreq; data_we = we; data_addr = addr; data_wdata = wdata;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a1 = ram_addr; be1 = ram_be_n;
                inst_addr = ~addr; data_addr = ~addr; data_wdata = ~wdata; data_we = ~we;
            end
            if (k == drop_k) begin inst_req = 1'b0; data_req = 1'b0; end
            if (!ram_oe_n) oe_c++;
            if (!ram_we_n) we_c++;
            if ((we != 4'b0000) && (ram_data === wdata)) bus_c++;
            if (inst_ack || data_ack) begin
                ack_c++;
                if (lat < 0) begin
                    lat = k;
                    who = (inst_ack && data_ack) ? 2 : (data_ack ? 1 : 0);
                    inst_req = 1'b0; data_req = 1'b0;
                end
            end
            if ((lat > 0) && (k >= lat + 2)) break;
        end
        data_we = 4'b0000;
    endtask

    typedef struct {
        logic        ireq;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [19:0] e_addr;
        logic [3:0]  e_be;
        int          e_lat;
        int          e_who;
        int          e_oe;
        int          e_we;
        int          e_bus;
        logic [31:0] e_word;   // read: owner rdata; write: memory word afterwards
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat, who, oe_c, we_c, bus_c, ack_c;
        logic [19:0] a1;
        logic [3:0]  be1;
        logic [31:0] exp_inst_rd, exp_data_rd;
        string seq;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[2] = 32'hAABBCCDD;
        mem[4] = 32'hDEADBEEF;

        //          ireq  we       addr          wdata         e_addr    e_be    lat who oe we bus e_word
        vecs[0] = '{1'b1, 4'b0000, 32'h8000_0010, 32'h0,        20'h00004, 4'b0000, 3, 0, 2, 0, 0, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 4'b0011, 32'h8040_0008, 32'h1234_5678, 20'h00002, 4'b1100, 5, 1, 0, 2, 4, 32'hAABB5678};
        vecs[2] = '{1'b0, 4'b0000, 32'h0000_0008, 32'h0,        20'h00002, 4'b0000, 3, 1, 2, 0, 0, 32'hAABB5678};
        vecs[3] = '{1'b0, 4'b1111, 32'h0000_0040, 32'hCAFE_F00D, 20'h00010, 4'b0000, 5, 1, 0, 2, 4, 32'hCAFEF00D};
        vecs[4] = '{1'b0, 4'b1000, 32'hFFFF_FFFF, 32'h1122_3344, 20'hFFFFF, 4'b0111, 5, 1, 0, 2, 4, 32'h11000000};
        vecs[5] = '{1'b1, 4'b0000, 32'h0000_0040, 32'h0,        20'h00010, 4'b0000, 3, 0, 2, 0, 0, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 4'b0000, 32'hC03F_FFFC, 32'h0,        20'hFFFFF, 4'b0000, 3, 1, 2, 0, 0, 32'h11000000};

        resetn = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_we = '0; data_addr = '0; data_wdata = '0;
        repeat (3) @(negedge clk);

        // ---- reset state ----
        chk("rst_inst_ack",   32'(inst_ack),   32'h0);
        chk("rst_data_ack",   32'(data_ack),   32'h0);
        chk("rst_inst_rdata", inst_rdata,      32'h0);
        chk("rst_data_rdata", data_rdata,      32'h0);
        chk("rst_ram_addr",   32'(ram_addr),   32'h0);
        chk("rst_be_n",       32'(ram_be_n),   32'hF);
        chk("rst_ctl_n",      32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h7);

        // ---- both requests from reset: data first, then strict alternation ----
        resetn = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h0000_0010;
        data_req = 1'b1; data_we = 4'b0000; data_addr = 32'h0000_0008;
        seq = "";
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (data_ack) begin
                seq = {seq, "D"};
                if (lat < 0) lat = k;
                chk("alt_data_rdata", data_rdata, 32'hAABBCCDD);
            end
            if (inst_ack) begin
                seq = {seq, "I"};
                chk("alt_inst_rdata", inst_rdata, 32'hDEADBEEF);
            end
            if (seq.len() >= 6) begin inst_req = 1'b0; data_req = 1'b0; break; end
        end
        inst_req = 1'b0; data_req = 1'b0;
        chk("alt_first_lat", 32'(lat), 32'd3);
        n_vec++;
        if (seq != "DIDIDI") begin
            n_err++;
            $display("FAIL alt_order: got %s expected DIDIDI", seq);
        end
        exp_data_rd = 32'hAABBCCDD;
        exp_inst_rd = 32'hDEADBEEF;
        repeat (2) @(negedge clk);

        // ---- table of single transactions ----
        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i].ireq, !vecs[i].ireq, vecs[i].we, vecs[i].addr, vecs[i].wdata, 0,
                   lat, who, oe_c, we_c, bus_c, ack_c, a1, be1);
            chk($sformatf("v%0d_ram_addr", i), 32'(a1),    32'(vecs[i].e_addr));
            chk($sformatf("v%0d_be_n", i),     32'(be1),   32'(vecs[i].e_be));
            chk($sformatf("v%0d_lat", i),      32'(lat),   32'(vecs[i].e_lat));
            chk($sformatf("v%0d_who", i),      32'(who),   32'(vecs[i].e_who));
            chk($sformatf("v%0d_acks", i),     32'(ack_c), 32'd1);
            chk($sformatf("v%0d_oe_cyc", i),   32'(oe_c),  32'(vecs[i].e_oe));
            chk($sformatf("v%0d_we_cyc", i),   32'(we_c),  32'(vecs[i].e_we));
            chk($sformatf("v%0d_bus_cyc", i),  32'(bus_c), 32'(vecs[i].e_bus));
            if (vecs[i].we != 4'b0000) begin
                chk($sformatf("v%0d_mem", i), mem[vecs[i].e_addr[7:0]], vecs[i].e_word);
            end else if (vecs[i].ireq) begin
                exp_inst_rd = vecs[i].e_word;
            end else begin
                exp_data_rd = vecs[i].e_word;
            end
            chk($sformatf("v%0d_inst_rdata", i), inst_rdata, exp_inst_rd);
            chk($sformatf("v%0d_data_rdata", i), data_rdata, exp_data_rd);
            $display("vector %0d: addr %h we %b lat %0d who %0d", i, vecs[i].addr, vecs[i].we, lat, who);
            @(negedge clk);
        end

        // ---- data_req dropped during RD: transaction still completes ----
        do_txn(1'b0, 1'b1, 4'b0000, 32'h0000_0040, 32'h0, 1,
               lat, who, oe_c, we_c, bus_c, ack_c, a1, be1);
        chk("drop_lat",   32'(lat),   32'd3);
        chk("drop_who",   32'(who),   32'd1);
        chk("drop_rdata", data_rdata, 32'hCAFEF00D);
        $display("drop sequence: lat %0d", lat);
        @(negedge clk);

        // ---- reset asserted during WR_PULSE ----
        data_req = 1'b1; data_we = 4'b1111; data_addr = 32'h0000_0080; data_wdata = 32'h55AA_55AA;
        repeat (2) @(negedge clk);
        chk("rstw_we_low", 32'(ram_we_n), 32'h0);
        #2 resetn = 1'b0;
        data_req = 1'b0; data_we = 4'b0000;
        #1;
        chk("rstw_we_n",  32'(ram_we_n), 32'h1);
        chk("rstw_ce_n",  32'(ram_ce_n), 32'h1);
        chk("rstw_bus",   32'(ram_data === 32'h55AA_55AA), 32'h0);
        chk("rstw_rdata", data_rdata, 32'h0);
        ack_c = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (inst_ack || data_ack) ack_c++;
        end
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (inst_ack || data_ack) ack_c++;
        end
        chk("rstw_no_ack", 32'(ack_c), 32'h0);
        do_txn(1'b1, 1'b0, 4'b0000, 32'h0000_0040, 32'h0, 0,
               lat, who, oe_c, we_c, bus_c, ack_c, a1, be1);
        chk("rstw_next_lat",   32'(lat),   32'd3);
        chk("rstw_next_rdata", inst_rdata, 32'hCAFEF00D);
        $display("reset-in-write sequence: next read lat %0d", lat);

        // ---- RD_WAIT=0 instance: single-cycle read strobe ----
        @(negedge clk);
        b_data_req = 1'b1; b_data_addr = 32'h0000_0010;
        lat = -1; oe_c = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!b_ram_oe_n) oe_c++;
            if (b_data_ack && lat < 0) begin lat = k; b_data_req = 1'b0; end
        end
        b_data_req = 1'b0;
        chk("rw0_lat",   32'(lat),     32'd2);
        chk("rw0_oe",    32'(oe_c),    32'd1);
        chk("rw0_rdata", b_data_rdata, 32'hDEADBEEF);
        $display("rd_wait0 read: lat %0d", lat);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter RD_WAIT, default 1: extra read-strobe cycles beyond the first.
REQ-002 SHALL have parameter WR_WAIT, default 1: extra write-pulse cycles beyond the first.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, as these ports:
- clk  in  1  sole clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_req  in  1  fetch request; held until inst_ack.
- inst_addr  in  32  fetch byte address.
- inst_ack  out  1  one-cycle completion pulse for fetch.
- inst_rdata  out  32  fetched word; valid while inst_ack=1.
- data_req  in  1  load/store request; held until data_ack.
- data_we  in  4  byte write strobes; 0000 = read.
- data_addr  in  32  data byte address.
- data_wdata  in  32  store data.
- data_ack  out  1  one-cycle completion pulse for data.
- data_rdata  out  32  load word; valid while data_ack=1.
- ram_data  inout  32  SRAM data bus.
- ram_addr  out  20  SRAM word address.
- ram_be_n  out  4  byte enables, active low.
- ram_ce_n  out  1  chip select, active low.
- ram_oe_n  out  1  output enable, active low.
- ram_we_n  out  1  write enable, active low.

Function
REQ-004 SHALL implement FSM states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-005 In IDLE, request sampling:
- only data_req set: grant data.
- only inst_req set: grant inst.
- both set: data wins unless the last completed grant was data, in which case inst wins.
REQ-006 At grant SHALL latch owner, addr[21:2], ~data_we (inst: 0000) and data_wdata; ram_addr = latched addr[21:2]; addr[31:22] and addr[1:0] ignored.
REQ-007 Read (inst, or data with data_we=0000) SHALL go IDLE -> RD, held RD_WAIT+1 cycles with ce_n=0, oe_n=0, we_n=1, be_n=0000, then -> DONE.
- ram_data is sampled into the owner's rdata register on the last RD cycle.
REQ-008 Write (data_we≠0000) SHALL sequence:
- WR_SETUP: 1 cycle, ce_n=0, we_n=1.
- WR_PULSE: WR_WAIT+1 cycles, we_n=0.
- WR_HOLD: 1 cycle, we_n=1.
- then -> DONE.
- oe_n=1 and be_n=latched strobes throughout.
REQ-009 DONE SHALL last exactly 1 cycle, assert the owner's ack only, return to IDLE; no new grant is sampled in DONE.
REQ-010 Latency from the IDLE cycle N that samples the request:
- read ack at cycle N+RD_WAIT+2.
- write ack at cycle N+WR_WAIT+4.
REQ-011 ram_data SHALL be driven with the latched wdata only in WR_SETUP, WR_PULSE and WR_HOLD; high-Z otherwise.
REQ-012 All ram_* controls and acks SHALL come from flops (glitch-free).
REQ-013 In IDLE and DONE: ce_n=1, oe_n=1, we_n=1.
REQ-014 A request dropped mid-transaction SHALL NOT abort; the transaction completes and ack still pulses.
REQ-015 Input changes after grant SHALL NOT affect the current transaction.
REQ-016 inst_rdata/data_rdata SHALL hold their last value until the next read for that port; a write SHALL NOT modify data_rdata.
REQ-017 Wait counters SHALL be wide enough for RD_WAIT/WR_WAIT up to 15 and reload per transaction; RD_WAIT=0 and WR_WAIT=0 are legal (single-cycle strobe).

Reset
REQ-018 resetn=0 SHALL asynchronously force, mid-operation included:
- state IDLE, counters 0, last-owner = inst.
- inst_ack=0, data_ack=0, inst_rdata=0, data_rdata=0.
- ram_addr=0, ram_be_n=1111, ram_ce_n=1, ram_oe_n=1, ram_we_n=1, ram_data high-Z.
REQ-019 First grant SHALL be sampleable in the first cycle after resetn rises.

Structure
REQ-020 Package sram_arb_pkg SHALL hold the FSM state enum, the owner type (INST/DATA) and default RD_WAIT/WR_WAIT constants.
REQ-021 No sub-module; FSM, counter and tristate driver in one module.

Verification
REQ-022 Bench SHALL cover, with RD_WAIT=WR_WAIT=1 unless stated:
- inst_req, addr 0x8000_0010, model word 0xDEADBEEF -> ram_addr=0x00004, oe_n low 2 cycles, inst_ack at N+3 with inst_rdata=0xDEADBEEF.
- data_we=0011, addr 0x8040_0008, wdata 0x1234_5678 -> be_n=1100, we_n low 2 cycles, bus driven 4 cycles, data_ack at N+5; model bytes 0,1 = 0x78,0x56.
- inst_req and data_req both set from reset -> data served first, then inst; repeat with both held -> strict alternation, no starvation.
- resetn pulsed low in WR_PULSE -> we_n=1, ce_n=1, bus Z immediately; no ack; next request behaves normally.
- data_req dropped after 1 cycle of RD -> data_ack still pulses at N+3; RD_WAIT=0 read -> ack at N+2.
